// File: rtl/seq_detector_param.sv
// Parameterised serial pattern detector with a loadable pattern, optional overlap and a saturating match counter.
// Define SEQ_DETECTOR_PARAM_CNT_EN to build the match counter; otherwise match_cnt is tied to zero.
module seq_detector_param #(
  parameter int unsigned      PAT_W     = 4,
  parameter int unsigned      CNT_W     = 8,
  parameter logic [PAT_W-1:0] RESET_PAT = PAT_W'(4'b1000)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             x,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  input  logic             cnt_clr,
  output logic             q,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned FILL_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0]  pat_reg;
  logic [PAT_W-1:0]  hist;
  logic [PAT_W-1:0]  win_c;
  logic [FILL_W-1:0] fill;
  logic              match_c;

  // Window includes the bit being sampled; fill counts bits collected before this edge.
  assign win_c   = {hist[PAT_W-2:0], x};
  assign match_c = en && !pat_load && (fill >= FILL_W'(PAT_W - 1)) && (win_c == pat_reg);

  always_ff @(posedge clk) begin
    if (!reset) begin
      pat_reg <= RESET_PAT;
      hist    <= '0;
      fill    <= '0;
      q       <= 1'b0;
    end else if (pat_load) begin
      pat_reg <= pattern;
      hist    <= '0;
      fill    <= '0;
      q       <= 1'b0;
    end else if (en) begin
      hist <= win_c;
      q    <= match_c;
      // Non-overlapping mode forces a fresh PAT_W bits before the next match.
      if (match_c && !overlap) begin
        fill <= '0;
      end else if (fill != FILL_W'(PAT_W)) begin
        fill <= fill + FILL_W'(1);
      end
    end else begin
      q <= 1'b0;
    end
  end

`ifdef SEQ_DETECTOR_PARAM_CNT_EN
  // Clear beats a coincident match; counting saturates at all-ones.
  always_ff @(posedge clk) begin
    if (!reset) begin
      match_cnt <= '0;
    end else if (cnt_clr) begin
      match_cnt <= '0;
    end else if (match_c && (match_cnt != {CNT_W{1'b1}})) begin
      match_cnt <= match_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed vector table, hand sequences and random stimulus against a queue-based model.
module tb_seq_detector_param;

`ifdef SEQ_DETECTOR_PARAM_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, en, x, pat_load, overlap, cnt_clr;
  logic [3:0] pattern;
  logic       q, q2;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt2;

  int errors = 0;
  int checks = 0;

  seq_detector_param dut (
    .clk(clk), .reset(reset), .en(en), .x(x), .pat_load(pat_load),
    .pattern(pattern), .overlap(overlap), .cnt_clr(cnt_clr),
    .q(q), .match_cnt(match_cnt)
  );

  seq_detector_param #(.PAT_W(4), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .en(en), .x(x), .pat_load(pat_load),
    .pattern(pattern), .overlap(overlap), .cnt_clr(cnt_clr),
    .q(q2), .match_cnt(match_cnt2)
  );

  always #5 clk = ~clk;

  // Reference model: bits sampled since the last clear, newest at the back.
  bit         hq[$];
  logic [3:0] m_pat;
  bit         m_q;
  int         m_cnt8, m_cnt2;

  task automatic model_update();
    bit         m;
    logic [3:0] w;
    m = 1'b0;
    if (!reset) begin
      hq.delete();
      m_pat  = 4'b1000;
      m_cnt8 = 0;
      m_cnt2 = 0;
    end else begin
      if (pat_load) begin
        m_pat = pattern;
        hq.delete();
      end else if (en) begin
        hq.push_back(x);
        if (hq.size() > 4) void'(hq.pop_front());
        if (hq.size() == 4) begin
          w = 4'b0;
          foreach (hq[i]) w = {w[2:0], logic'(hq[i])};
          m = (w == m_pat);
        end
        if (m && !overlap) hq.delete();
      end
      if (cnt_clr) begin
        m_cnt8 = 0;
        m_cnt2 = 0;
      end else if (m) begin
        m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
        m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
      end
    end
    m_q = m;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int cexp(input int v);
    return CNT_EN ? v : 0;
  endfunction

  task automatic step(input logic r, input logic e, input logic xx, input logic l,
                      input logic [3:0] p, input logic ov, input logic c);
    reset = r; en = e; x = xx; pat_load = l; pattern = p; overlap = ov; cnt_clr = c;
    @(posedge clk);
    model_update();
    #1;
  endtask

  typedef struct {
    logic       rst, en, x, load;
    logic [3:0] pat;
    logic       ov, clr, eq;
    int         ecnt;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic rst, input logic e, input logic xx, input logic l,
                              input logic [3:0] p, input logic ov, input logic c,
                              input logic eq, input int ecnt);
    vec_t v;
    v.rst = rst; v.en = e; v.x = xx; v.load = l; v.pat = p;
    v.ov = ov; v.clr = c; v.eq = eq; v.ecnt = ecnt;
    tbl.push_back(v);
  endfunction

  initial begin
    // Reset defaults, pattern 1000
    add(0, 1, 1, 0, 4'h0, 1, 0, 0, 0);
    add(1, 1, 1, 0, 4'h0, 1, 0, 0, 0);
    add(1, 1, 0, 0, 4'h0, 1, 0, 0, 0);
    add(1, 1, 0, 0, 4'h0, 1, 0, 0, 0);
    add(1, 1, 0, 0, 4'h0, 1, 0, 1, 1);
    add(1, 0, 1, 0, 4'h0, 1, 0, 0, 1);
    // Pattern 1010 overlapping (load with en=1, x=1 ignored)
    add(1, 1, 1, 1, 4'hA, 1, 1, 0, 0);
    add(1, 1, 1, 0, 4'h0, 1, 0, 0, 0);
    add(1, 1, 0, 0, 4'h0, 1, 0, 0, 0);
    add(1, 1, 1, 0, 4'h0, 1, 0, 0, 0);
    add(1, 1, 0, 0, 4'h0, 1, 0, 1, 1);
    add(1, 1, 1, 0, 4'h0, 1, 0, 0, 1);
    add(1, 1, 0, 0, 4'h0, 1, 0, 1, 2);
    // Pattern 1010 non-overlapping
    add(1, 1, 1, 1, 4'hA, 0, 1, 0, 0);
    add(1, 1, 1, 0, 4'h0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 4'h0, 0, 0, 0, 0);
    add(1, 1, 1, 0, 4'h0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 4'h0, 0, 0, 1, 1);
    add(1, 1, 1, 0, 4'h0, 0, 0, 0, 1);
    add(1, 1, 0, 0, 4'h0, 0, 0, 0, 1);
    // Pattern 0000 needs four real samples
    add(1, 0, 0, 1, 4'h0, 1, 1, 0, 0);
    add(1, 1, 0, 0, 4'h0, 1, 0, 0, 0);
    add(1, 1, 0, 0, 4'h0, 1, 0, 0, 0);
    add(1, 1, 0, 0, 4'h0, 1, 0, 0, 0);
    add(1, 1, 0, 0, 4'h0, 1, 0, 1, 1);
    // Reset mid-sequence discards history
    add(0, 1, 0, 0, 4'h0, 1, 0, 0, 0);
    add(1, 1, 1, 0, 4'h0, 1, 0, 0, 0);
    add(1, 1, 0, 0, 4'h0, 1, 0, 0, 0);
    add(1, 1, 0, 0, 4'h0, 1, 0, 0, 0);
    add(0, 1, 0, 0, 4'h0, 1, 0, 0, 0);
    add(1, 1, 0, 0, 4'h0, 1, 0, 0, 0);
    add(1, 1, 1, 0, 4'h0, 1, 0, 0, 0);
    add(1, 1, 0, 0, 4'h0, 1, 0, 0, 0);
    add(1, 1, 0, 0, 4'h0, 1, 0, 0, 0);
    add(1, 1, 0, 0, 4'h0, 1, 0, 1, 1);
    // en=0 gap holds history
    add(1, 1, 1, 0, 4'h0, 1, 0, 0, 1);
    add(1, 0, 0, 0, 4'h0, 1, 0, 0, 1);
    add(1, 1, 0, 0, 4'h0, 1, 0, 0, 1);
    add(1, 1, 0, 0, 4'h0, 1, 0, 0, 1);
    add(1, 1, 0, 0, 4'h0, 1, 0, 1, 2);
    // Clear coincident with a match: clear wins, q still pulses
    add(1, 1, 1, 0, 4'h0, 1, 0, 0, 2);
    add(1, 1, 0, 0, 4'h0, 1, 0, 0, 2);
    add(1, 1, 0, 0, 4'h0, 1, 0, 0, 2);
    add(1, 1, 0, 0, 4'h0, 1, 1, 1, 0);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].en, tbl[i].x, tbl[i].load, tbl[i].pat, tbl[i].ov, tbl[i].clr);
      chk($sformatf("vec%0d_q", i), int'(q), int'(tbl[i].eq));
      chk($sformatf("vec%0d_cnt", i), int'(match_cnt), cexp(tbl[i].ecnt));
    end

    // 2-bit counter: all-ones pattern held for ten samples
    step(1, 1, 0, 1, 4'hF, 1, 1);
    chk("sat_load_q2", int'(q2), 0);
    chk("sat_load_cnt2", int'(match_cnt2), 0);
    for (int i = 1; i <= 10; i++) begin
      step(1, 1, 1, 0, 4'h0, 1, 0);
      chk($sformatf("sat%0d_q2", i), int'(q2), (i >= 4) ? 1 : 0);
      chk($sformatf("sat%0d_cnt2", i), int'(match_cnt2), cexp((i < 4) ? 0 : ((i - 3 > 3) ? 3 : i - 3)));
    end
    step(1, 1, 1, 0, 4'h0, 1, 1);
    chk("sat_clr_q2", int'(q2), 1);
    chk("sat_clr_cnt2", int'(match_cnt2), 0);

    // Randomised run against the model
    begin
      logic ov_r;
      ov_r = 1'b1;
      step(0, 1, 0, 0, 4'h0, 1, 0);
      for (int i = 0; i < 800; i++) begin
        if ($urandom_range(0, 19) == 0) ov_r = ~ov_r;
        step(logic'($urandom_range(0, 99) != 0), logic'($urandom_range(0, 7) != 0),
             logic'($urandom_range(0, 1)), logic'($urandom_range(0, 39) == 0),
             4'($urandom_range(0, 15)), ov_r, logic'($urandom_range(0, 29) == 0));
        chk($sformatf("rnd%0d_q", i), int'(q), int'(m_q));
        chk($sformatf("rnd%0d_q2", i), int'(q2), int'(m_q));
        chk($sformatf("rnd%0d_cnt", i), int'(match_cnt), cexp(m_cnt8));
        chk($sformatf("rnd%0d_cnt2", i), int'(match_cnt2), cexp(m_cnt2));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 Parameter PAT_W, default 4, pattern length in bits (legal 2..16).
REQ-002 Parameter CNT_W, default 8, match-counter width in bits.
REQ-003 Parameter RESET_PAT, default 4'b1000 zero-extended to PAT_W, pattern value loaded at reset.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  reset; synchronous, active-low.
REQ-006 en  input  1  when 1, sample x this cycle.
REQ-007 x  input  1  serial data bit.
REQ-008 pat_load  input  1  when 1, latch pattern into the internal pattern register.
REQ-009 pattern  input  PAT_W  new pattern; MSB is the first bit of the sequence.
REQ-010 overlap  input  1  1 = overlapping matches allowed; 0 = history cleared after each match.
REQ-011 cnt_clr  input  1  when 1, clear match_cnt.
REQ-012 q  output  1  registered match pulse.
REQ-013 match_cnt  output  CNT_W  registered count of matches.

Function
REQ-014 State: pattern register pat_reg[PAT_W], history shift register hist[PAT_W], fill counter fill (0..PAT_W, saturating), q, match_cnt.
REQ-015 On an edge with en=1 and pat_load=0: win = {hist[PAT_W-2:0], x}; hist <= win; fill <= min(fill+1, PAT_W).
REQ-016 Match condition on that edge: (fill+1 >= PAT_W) and (win == pat_reg).
REQ-017 q SHALL be 1 for exactly the one cycle following an edge on which the match condition holds, and 0 otherwise.
REQ-018 Latency: the last pattern bit is sampled at edge k; q is high from edge k to edge k+1.
REQ-019 Back-to-back matches in overlap mode SHALL hold q high on consecutive cycles.
REQ-020 When overlap=0 and a match occurs, fill SHALL become 0 instead of saturating, so the next match requires PAT_W new bits.
REQ-021 When overlap=1, fill is unaffected by a match.
REQ-022 en=0 holds hist, fill, and match_cnt, and drives q to 0 on the next edge.
REQ-023 pat_load=1 loads pat_reg <= pattern, clears hist and fill to 0, and drives q to 0 on the next edge; x is ignored that cycle regardless of en.
REQ-024 A change of overlap takes effect on the next sampled bit; stored history is kept.
REQ-025 match_cnt increments by 1 on every match and saturates at 2^CNT_W-1 without wrapping.
REQ-026 When cnt_clr and a match occur on the same edge, cnt_clr SHALL win and match_cnt becomes 0; q still pulses.
REQ-027 Until PAT_W bits have been sampled since reset or load, no match SHALL be reported even if hist zeros equal pat_reg.

Reset
REQ-028 When reset=0 at a rising edge: q=0, match_cnt=0, hist=0, fill=0, pat_reg=RESET_PAT; all other inputs are ignored.
REQ-029 A reset applied mid-sequence SHALL discard partial history; detection restarts from zero bits.
REQ-030 The block SHALL contain no asynchronous reset paths.

Configuration
REQ-031 Macro SEQ_DETECTOR_PARAM_CNT_EN: when defined, the match counter and cnt_clr are implemented as in REQ-025 and REQ-026.
REQ-032 When SEQ_DETECTOR_PARAM_CNT_EN is undefined, match_cnt SHALL be tied to 0, cnt_clr is ignored, the ports remain present, and no counter flops are inferred.

Verification
REQ-033 Reset defaults, en=1, x = 1,0,0,0 -> q=1 in exactly the cycle after the 4th sample; match_cnt=1.
REQ-034 pat_load pattern=4'b1010, overlap=1, x = 1,0,1,0,1,0 -> q pulses after samples 4 and 6; match_cnt=2.
REQ-035 Same stimulus with overlap=0 -> q pulses after sample 4 only; match_cnt=1.
REQ-036 pattern=4'b0000 loaded, x = 0,0,0 -> q stays 0; a 4th 0 -> q=1 (REQ-027).
REQ-037 Reset asserted after 1,0,0, then released, then x = 0 -> no q pulse; then 1,0,0,0 -> q=1.
REQ-038 CNT_W=2, overlap=1, pattern=1111, x = 1 held for 10 samples -> q high for 7 consecutive cycles; match_cnt saturates at 3; cnt_clr coincident with a match -> match_cnt=0.
